// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline hazard types: FSM encoding, register constants
//            and the stage-control bundle field order.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fsm_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Field order shared by every pipe register's stall/flush bundle, MSB first.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard inputs from the pipeline and stage controls back to it.
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             id_branch_taken_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_stall_o;
    logic             id_ex_flush_o;
    logic             ex_mem_stall_o;
    logic             mem_wb_flush_o;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               id_branch_taken_i, mem_req_i, mem_ready_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, busy_o,
               err_o, stall_cnt_o
    );

    // Hazard controller side
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               id_branch_taken_i, mem_req_i, mem_ready_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, busy_o,
               err_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use compare between the EX load and ID sources.
// Revision : 1.0
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
(
    input  wire logic [4:0] id_rs_i,
    input  wire logic [4:0] id_rt_i,
    input  wire logic       id_uses_rt_i,
    input  wire logic       ex_memread_i,
    input  wire logic [4:0] ex_rt_i,
    output logic            load_use_o
);
    logic rs_match;
    logic rt_match;

    // Writes to r0 are discarded, so a load targeting r0 never creates a hazard.
    assign rs_match   = (ex_rt_i == id_rs_i);
    assign rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
    assign load_use_o = ex_memread_i && (ex_rt_i != REG_ZERO) && (rs_match || rt_match);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline with memory-wait
//            FSM, timeout flag and saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    fsm_e              fsm_q,       fsm_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic        mem_hold;
    logic        load_use;
    stage_ctrl_t ctrl;

    // A dropped request while waiting counts as completion, so both states share one hold term.
    assign mem_hold = bus.mem_req_i && !bus.mem_ready_i;

    hazard_detect u_hazard_detect (
        .id_rs_i      (bus.id_rs_i),
        .id_rt_i      (bus.id_rt_i),
        .id_uses_rt_i (bus.id_uses_rt_i),
        .ex_memread_i (bus.ex_memread_i),
        .ex_rt_i      (bus.ex_rt_i),
        .load_use_o   (load_use)
    );

    always_comb begin
        ctrl = CTRL_NONE;
        if (mem_hold) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (load_use) begin
            // Any taken branch now is dropped and re-resolved once the bubble passes.
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (bus.id_branch_taken_i) begin
            ctrl.if_id_flush  = 1'b1;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (fsm_q)
            RUN: begin
                if (mem_hold) begin
                    fsm_d      = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (!mem_hold) begin
                    fsm_d      = RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        err_d = 1'b1;
                    end
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end
            end
            default: begin
                fsm_d      = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm_q       <= RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_stall_o     = ctrl.pc_stall;
    assign bus.if_id_stall_o  = ctrl.if_id_stall;
    assign bus.if_id_flush_o  = ctrl.if_id_flush;
    assign bus.id_ex_stall_o  = ctrl.id_ex_stall;
    assign bus.id_ex_flush_o  = ctrl.id_ex_flush;
    assign bus.ex_mem_stall_o = ctrl.ex_mem_stall;
    assign bus.mem_wb_flush_o = ctrl.mem_wb_flush;
    assign bus.busy_o         = (fsm_q == MEM_WAIT);
    assign bus.err_o          = err_q;
    assign bus.stall_cnt_o    = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [6:0] EXP_NONE = 7'b0000000;
    localparam logic [6:0] EXP_FULL = 7'b1101011;
    localparam logic [6:0] EXP_LU   = 7'b1100100;
    localparam logic [6:0] EXP_BR   = 7'b0010000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [6:0] ctrl_v;
    assign ctrl_v = {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o, bus.id_ex_stall_o,
                     bus.id_ex_flush_o, bus.ex_mem_stall_o, bus.mem_wb_flush_o};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_inputs();
        bus.id_rs_i           = '0;
        bus.id_rt_i           = '0;
        bus.id_uses_rt_i      = 1'b0;
        bus.ex_memread_i      = 1'b0;
        bus.ex_rt_i           = '0;
        bus.id_branch_taken_i = 1'b0;
        bus.mem_req_i         = 1'b0;
        bus.mem_ready_i       = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rt);
        bus.ex_memread_i = 1'b1;
        bus.ex_rt_i      = rt;
        bus.id_rs_i      = rt;
    endtask

    initial begin
        clr_inputs();
        rst_i = 1'b0;
        step();
        step();
        check_eq("rst_ctrl", 32'(ctrl_v), 32'(EXP_NONE));
        check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("rst_err",  32'(bus.err_o), 32'd0);
        check_eq("rst_cnt",  32'(bus.stall_cnt_o), 32'd0);
        rst_i = 1'b1;

        // Load-use on rs, then the r0 guard
        set_lu(5'd5);
        #2 check_eq("lu_rs", 32'(ctrl_v), 32'(EXP_LU));
        step();
        bus.ex_rt_i = 5'd0;
        bus.id_rs_i = 5'd0;
        #2 check_eq("lu_r0", 32'(ctrl_v), 32'(EXP_NONE));
        step();

        // Load-use on rt with a taken branch; the branch waits a cycle
        clr_inputs();
        bus.ex_memread_i      = 1'b1;
        bus.ex_rt_i           = 5'd7;
        bus.id_rt_i           = 5'd7;
        bus.id_rs_i           = 5'd3;
        bus.id_uses_rt_i      = 1'b1;
        bus.id_branch_taken_i = 1'b1;
        #2 check_eq("lu_br", 32'(ctrl_v), 32'(EXP_LU));
        step();
        check_eq("cnt_after_lu", 32'(bus.stall_cnt_o), 32'd2);
        bus.ex_memread_i = 1'b0;
        #2 check_eq("br_only", 32'(ctrl_v), 32'(EXP_BR));
        step();
        bus.id_branch_taken_i = 1'b0;
        bus.ex_memread_i      = 1'b1;
        bus.id_uses_rt_i      = 1'b0;
        #2 check_eq("rt_unused", 32'(ctrl_v), 32'(EXP_NONE));
        step();

        // Memory wait: 3 held cycles then ready
        clr_inputs();
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 check_eq($sformatf("mw_ctrl%0d", i), 32'(ctrl_v), 32'(EXP_FULL));
            check_eq($sformatf("mw_busy%0d", i), 32'(bus.busy_o), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        bus.mem_ready_i = 1'b1;
        #2 check_eq("mw_ready_ctrl", 32'(ctrl_v), 32'(EXP_NONE));
        check_eq("mw_ready_busy", 32'(bus.busy_o), 32'd1);
        step();
        check_eq("mw_done_busy", 32'(bus.busy_o), 32'd0);
        check_eq("mw_cnt", 32'(bus.stall_cnt_o), 32'd5);

        // Memory wait overrides load-use, which surfaces on the ready cycle
        clr_inputs();
        set_lu(5'd5);
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2 check_eq($sformatf("mwlu_ctrl%0d", i), 32'(ctrl_v), 32'(EXP_FULL));
            step();
        end
        bus.mem_ready_i = 1'b1;
        #2 check_eq("mwlu_ready", 32'(ctrl_v), 32'(EXP_LU));
        step();
        check_eq("mwlu_cnt", 32'(bus.stall_cnt_o), 32'd8);
        check_eq("mwlu_err", 32'(bus.err_o), 32'd0);

        // Timeout after the 4th stalled cycle, sticky through completion
        clr_inputs();
        bus.mem_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq($sformatf("to_err%0d", i), 32'(bus.err_o), (i == 4) ? 32'd1 : 32'd0);
        end
        bus.mem_ready_i = 1'b1;
        #2 check_eq("to_ready_ctrl", 32'(ctrl_v), 32'(EXP_NONE));
        step();
        check_eq("to_sticky", 32'(bus.err_o), 32'd1);
        check_eq("to_busy", 32'(bus.busy_o), 32'd0);
        check_eq("to_cnt", 32'(bus.stall_cnt_o), 32'd12);

        // Dropped request while waiting ends the wait
        clr_inputs();
        bus.mem_req_i = 1'b1;
        step();
        check_eq("drop_busy1", 32'(bus.busy_o), 32'd1);
        bus.mem_req_i = 1'b0;
        #2 check_eq("drop_ctrl", 32'(ctrl_v), 32'(EXP_NONE));
        step();
        check_eq("drop_busy0", 32'(bus.busy_o), 32'd0);
        check_eq("drop_cnt", 32'(bus.stall_cnt_o), 32'd13);

        // Asynchronous reset mid-wait
        bus.mem_req_i = 1'b1;
        step();
        check_eq("arst_pre_busy", 32'(bus.busy_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check_eq("arst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("arst_err",  32'(bus.err_o), 32'd0);
        check_eq("arst_cnt",  32'(bus.stall_cnt_o), 32'd0);
        clr_inputs();
        step();
        rst_i = 1'b1;

        // Stall counter saturation
        set_lu(5'd9);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check_eq("sat14", 32'(bus.stall_cnt_o), 32'd14);
            if (i == 15) check_eq("sat15", 32'(bus.stall_cnt_o), 32'd15);
        end
        check_eq("sat20", 32'(bus.stall_cnt_o), 32'd15);
        clr_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
